// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential 32/16 and 16/8 divider.
package div_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StIter,
        StFix,
        StDone
    } div_state_t;

    localparam int unsigned WordSteps = 16;
    localparam int unsigned ByteSteps = 8;

    function automatic logic [4:0] step_count(logic word);
        return word ? 5'(WordSteps) : 5'(ByteSteps);
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between a divider client and div_seq.
interface div_seq_if;
    logic        start;
    logic [31:0] x;
    logic [15:0] y;
    logic        signed_op;
    logic        word_op;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        div_exc;

    modport master (
        output start, x, y, signed_op, word_op,
        input  out, busy, done, div_exc
    );

    modport slave (
        input  start, x, y, signed_op, word_op,
        output out, busy, done, div_exc
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on magnitudes.
module div_step (
    input  logic [16:0] rem,
    input  logic        dividend_bit,
    input  logic [15:0] divisor,
    output logic [16:0] rem_next,
    output logic        q_bit
);
    logic [17:0] shifted;
    logic [16:0] diff;

    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = shifted[16:0] - {1'b0, divisor};
        q_bit    = shifted >= {2'b00, divisor};
        rem_next = q_bit ? diff : shifted[16:0];
    end
endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider: 32/16 word or 16/8 byte, x86 DIV/IDIV style.
module div_seq
    import div_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    div_state_t  state_q, state_d;
    logic [16:0] rem_q;
    logic [15:0] quo_q;
    logic [15:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        sx_q, sy_q, word_q, signed_q, exc_q;
    logic [31:0] out_q;

    logic        accept;
    logic [31:0] dvd_w, mag_w;
    logic [15:0] dvd_b, mag_b, mag_y;
    logic        setup_exc;
    logic [16:0] step_rem;
    logic        step_bit;
    logic        neg_q, fix_exc;
    logic [15:0] q_mag, half, q_w, r_w;
    logic [7:0]  q_b, r_b;
    logic [31:0] out_d;

    assign accept = bus.start && (state_q == StIdle || state_q == StDone);

    // Magnitudes and early range check, evaluated while in SETUP.
    always_comb begin
        dvd_w     = {rem_q[15:0], quo_q};
        dvd_b     = {rem_q[7:0], quo_q[15:8]};
        mag_w     = sx_q ? -dvd_w : dvd_w;
        mag_b     = sx_q ? -dvd_b : dvd_b;
        mag_y     = word_q ? (sy_q ? -dvs_q : dvs_q)
                           : {8'h00, (sy_q ? -dvs_q[7:0] : dvs_q[7:0])};
        setup_exc = (mag_y == 16'h0000) ||
                    (word_q ? (mag_w[31:16] >= mag_y) : ({8'h00, mag_b[15:8]} >= mag_y));
    end

    div_step u_step (
        .rem          (rem_q),
        .dividend_bit (quo_q[15]),
        .divisor      (dvs_q),
        .rem_next     (step_rem),
        .q_bit        (step_bit)
    );

    // Sign application and signed range check, evaluated while in FIX.
    always_comb begin
        neg_q   = sx_q ^ sy_q;
        q_mag   = word_q ? quo_q : {8'h00, quo_q[7:0]};
        half    = word_q ? 16'h8000 : 16'h0080;
        fix_exc = signed_q && (neg_q ? (q_mag > half) : (q_mag >= half));
        q_w     = neg_q ? -quo_q : quo_q;
        r_w     = sx_q ? -rem_q[15:0] : rem_q[15:0];
        q_b     = neg_q ? -quo_q[7:0] : quo_q[7:0];
        r_b     = sx_q ? -rem_q[7:0] : rem_q[7:0];
        out_d   = word_q ? {r_w, q_w} : {16'h0000, r_b, q_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StSetup;
            StSetup: state_d = setup_exc ? StDone : StIter;
            StIter:  if (cnt_q == 5'd1) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = bus.start ? StSetup : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            word_q   <= 1'b0;
            signed_q <= 1'b0;
            exc_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        // Raw operands are parked in the datapath until SETUP.
                        word_q   <= bus.word_op;
                        signed_q <= bus.signed_op;
                        exc_q    <= 1'b0;
                        sx_q     <= bus.signed_op & (bus.word_op ? bus.x[31] : bus.x[15]);
                        sy_q     <= bus.signed_op & (bus.word_op ? bus.y[15] : bus.y[7]);
                        rem_q    <= bus.word_op ? {1'b0, bus.x[31:16]} : {9'h000, bus.x[15:8]};
                        quo_q    <= bus.word_op ? bus.x[15:0] : {bus.x[7:0], 8'h00};
                        dvs_q    <= bus.word_op ? bus.y : {8'h00, bus.y[7:0]};
                    end
                end
                StSetup: begin
                    exc_q <= setup_exc;
                    if (!setup_exc) begin
                        rem_q <= word_q ? {1'b0, mag_w[31:16]} : {9'h000, mag_b[15:8]};
                        quo_q <= word_q ? mag_w[15:0] : {mag_b[7:0], 8'h00};
                        dvs_q <= mag_y;
                        cnt_q <= step_count(word_q);
                    end
                end
                StIter: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[14:0], step_bit};
                    cnt_q <= cnt_q - 5'd1;
                end
                StFix: begin
                    exc_q <= fix_exc;
                    if (!fix_exc) out_q <= out_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = (state_q == StSetup) || (state_q == StIter) || (state_q == StFix);
    assign bus.done    = (state_q == StDone);
    assign bus.div_exc = (state_q == StDone) && exc_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq.
module tb_div_seq;
    logic clk;
    logic rst;
    div_seq_if bus ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int lat;
    int seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly the accept edge, then scramble the inputs.
    task automatic issue(input logic [31:0] x, input logic [15:0] y, input logic s,
                         input logic w);
        bus.x         = x;
        bus.y         = y;
        bus.signed_op = s;
        bus.word_op   = w;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.x         = 32'hDEAD_BEEF;
        bus.y         = 16'hA5A5;
        bus.signed_op = ~s;
        bus.word_op   = ~w;
    endtask

    // Latency is the number of the edge (relative to accept) that first samples done high.
    task automatic wait_done(input int base, output int l);
        int c;
        c = base;
        while (bus.done !== 1'b1 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        l = c + 1;
    endtask

    task automatic run(input string tag, input logic [31:0] x, input logic [15:0] y,
                       input logic s, input logic w, input logic [31:0] exp_out,
                       input logic exp_exc, input int exp_lat);
        int l;
        issue(x, y, s, w);
        wait_done(0, l);
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
        check({tag, "_out"}, bus.out, exp_out);
        check({tag, "_exc"}, {31'd0, bus.div_exc}, {31'd0, exp_exc});
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {30'd0, bus.done, bus.div_exc}, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.signed_op = 1'b0;
        bus.word_op   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", bus.out, 32'd0);
        check("rst_flags", {29'd0, bus.busy, bus.done, bus.div_exc}, 32'd0);
        rst = 1'b0;

        run("u_word",    32'h0001_0000, 16'h0003, 1'b0, 1'b1, 32'h0001_5555, 1'b0, 19);
        run("u_byte",    32'h1234_0064, 16'hAB07, 1'b0, 1'b0, 32'h0000_020E, 1'b0, 11);
        run("s_word",    32'hFFFF_FFF9, 16'h0002, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 19);
        run("exc_zero",  32'h0000_1234, 16'h0000, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1, 2);
        run("exc_ovf_u", 32'h0002_0000, 16'h0002, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1, 2);
        run("exc_ovf_s", 32'h0000_8000, 16'h0001, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b1, 19);
        run("s_byte",    32'h0000_FF9C, 16'h0007, 1'b1, 1'b0, 32'h0000_FEF2, 1'b0, 11);
        run("s_byte_min", 32'h0000_FF80, 16'h0001, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 11);
        run("s_byte_ovf", 32'h0000_FF80, 16'h00FF, 1'b1, 1'b0, 32'h0000_0080, 1'b1, 11);
        run("s_word_ny", 32'h0000_0064, 16'hFFF9, 1'b1, 1'b1, 32'h0002_FFF2, 1'b0, 19);

        // Start pulsed at k+5 while busy must be ignored.
        issue(32'h0000_03E8, 16'h000A, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.x     = 32'h0000_0001;
        bus.y     = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_mid", {31'd0, bus.busy}, 32'd1);
        wait_done(5, lat);
        check("busy_ign_lat", 32'(lat), 32'd19);
        check("busy_ign_out", bus.out, 32'h0000_0064);
        check("busy_ign_exc", {31'd0, bus.div_exc}, 32'd0);

        // Back-to-back start while done is high.
        issue(32'h0000_00FF, 16'h0010, 1'b0, 1'b1);
        check("b2b_accept", {30'd0, bus.busy, bus.done}, 32'd2);
        wait_done(0, lat);
        check("b2b_lat", 32'(lat), 32'd19);
        check("b2b_out", bus.out, 32'h000F_000F);
        @(posedge clk);
        #1;
        check("b2b_pulse", {31'd0, bus.done}, 32'd0);

        // Reset in the middle of a word divide.
        issue(32'h0001_0000, 16'h0003, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out", bus.out, 32'd0);
        check("mid_rst_flags", {29'd0, bus.busy, bus.done, bus.div_exc}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        check("mid_rst_nodone", 32'(seen), 32'd0);
        run("post_rst", 32'h0000_0064, 16'h000A, 1'b0, 1'b1, 32'h0000_000A, 1'b0, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
